// File: rtl/rx_filter_sequencer.sv
// Receive FIR sequencer: feeds burst samples into an external FIR, flushes the delay line,
// decimates the FIR output into a small FWFT FIFO. Optional feature: RX_FILTER_SEQUENCER_STATS_EN.
module rx_filter_sequencer #(
   parameter int unsigned TAPS       = 65,
   parameter int unsigned DELAY      = 32,
   parameter int unsigned DECIM      = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [15:0] fir_din,
   output logic        fir_en,
   input  logic [15:0] fir_dout,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy
`ifdef RX_FILTER_SEQUENCER_STATS_EN
   ,
   output logic [15:0] sym_count
`endif
);

   localparam int unsigned DW  = 16;
   localparam int unsigned SW  = 32;
   localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned PHW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int unsigned FW  = (TAPS > 2) ? $clog2(TAPS) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]     state, state_nx;
   logic [SW-1:0]  scnt;
   logic [PHW-1:0] ph;
   logic [FW-1:0]  fcnt;
   logic           cap_pend, cap_last;
   logic [DW:0]    mem [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           permit, past_delay, in_window, eligible, final_cap, push, pop;

   // Headroom of two keeps room for the in-flight result plus the one this shift may create.
   assign permit     = (32'(count) + 32'(cap_pend) + 32'd2) <= 32'(FIFO_DEPTH);
   assign past_delay = scnt >= SW'(DELAY);
   assign in_window  = (state != S_FLUSH) || (32'(fcnt) < 32'(DELAY));
   assign eligible   = fir_en && past_delay && (ph == '0) && in_window;
   // Assumes DECIM <= DELAY, so the final symbol always comes from a flush shift.
   assign final_cap  = (state == S_FLUSH) && ((32'(fcnt) + 32'(DECIM) + 32'd1) > 32'(DELAY));

   assign push      = cap_pend;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem[rd_ptr][DW-1:0] : '0;
   assign out_last  = out_valid ? mem[rd_ptr][DW] : 1'b0;
   assign busy      = (state != S_IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next state and handshake outputs
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      fir_en   = 1'b0;
      fir_din  = '0;
      case (state)
         S_IDLE, S_RUN: begin
            in_ready = permit;
            if (in_valid && permit) begin
               fir_en   = 1'b1;
               fir_din  = in_data;
               state_nx = in_last ? S_FLUSH : S_RUN;
            end
         end
         S_FLUSH: begin
            fir_en = permit;
            if (permit && (fcnt == FW'(TAPS - 2))) state_nx = S_DRAIN;
         end
         default: begin
            if ((count == '0) && !cap_pend) state_nx = S_IDLE;
         end
      endcase
      if (reset) begin
         in_ready = 1'b0;
         fir_en   = 1'b0;
         fir_din  = '0;
         state_nx = S_IDLE;
      end
   end

   // Shift bookkeeping, capture pipeline and FIFO pointers
   always_ff @(posedge clk) begin
      if (reset) begin
         scnt     <= '0;
         ph       <= '0;
         fcnt     <= '0;
         cap_pend <= 1'b0;
         cap_last <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if ((state == S_DRAIN) && (state_nx == S_IDLE)) begin
            scnt <= '0;
            ph   <= '0;
            fcnt <= '0;
         end else if (fir_en) begin
            scnt <= scnt + SW'(1);
            if (past_delay) ph <= (ph == PHW'(DECIM - 1)) ? '0 : ph + PHW'(1);
            if (state == S_FLUSH) fcnt <= fcnt + FW'(1);
         end
         cap_pend <= eligible;
         cap_last <= eligible && final_cap;
         if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage: {last, data}
   always_ff @(posedge clk) begin
      if (push && !reset) mem[wr_ptr] <= {cap_last, fir_dout};
   end

`ifdef RX_FILTER_SEQUENCER_STATS_EN
   // Symbols popped in the current or most recent burst
   always_ff @(posedge clk) begin
      if (reset)                                     sym_count <= '0;
      else if ((state == S_IDLE) && fir_en)          sym_count <= '0;
      else if (pop && (sym_count != 16'hFFFF))       sym_count <= sym_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_rx_filter_sequencer.sv
// Bench for rx_filter_sequencer: pure-delay FIR model plus symbol scoreboard.
module tb_rx_filter_sequencer;

   localparam int unsigned TAPS       = 65;
   localparam int unsigned DELAY      = 32;
   localparam int unsigned DECIM      = 4;
   localparam int unsigned FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [15:0] fir_din;
   logic        fir_en;
   logic [15:0] fir_dout;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_last;
   logic        busy;
`ifdef RX_FILTER_SEQUENCER_STATS_EN
   logic [15:0] sym_count;
`endif

   rx_filter_sequencer #(
      .TAPS(TAPS), .DELAY(DELAY), .DECIM(DECIM), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .fir_din(fir_din), .fir_en(fir_en), .fir_dout(fir_dout),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy)
`ifdef RX_FILTER_SEQUENCER_STATS_EN
      , .sym_count(sym_count)
`endif
   );

   always #5 clk = ~clk;

   // FIR model: result after a shift is the sample DELAY shifts older
   logic [15:0] fir_line [TAPS];
   always @(posedge clk) begin
      if (fir_en) begin
         for (int i = TAPS - 1; i > 0; i--) fir_line[i] <= fir_line[i-1];
         fir_line[0] <= fir_din;
         fir_dout    <= fir_line[DELAY-1];
      end
   end

   int          checks = 0;
   int          errors = 0;
   int          pops = 0;
   int          fen_cnt = 0;
   int          flush_cnt = 0;
   logic [16:0] sb [$];
   logic [16:0] e_sym;
   logic [15:0] samp [64];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, want);
      end
   endtask

   // Output monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (!reset) begin
         if (fir_en) begin
            fen_cnt++;
            if (!in_ready) flush_cnt++;
         end
         if (out_valid && out_ready) begin
            pops++;
            if (sb.size() == 0) check("extra_symbol", 32'd1, 32'd0);
            else begin
               e_sym = sb.pop_front();
               check("sym_data", 32'(out_data), 32'(e_sym[15:0]));
               check("sym_last", 32'(out_last), 32'(e_sym[16]));
            end
         end
      end
   end

   task automatic send_burst(input int n, input bit with_last);
      int last_sym;
      int t;
      last_sym = ((n - 1) / int'(DECIM)) * int'(DECIM);
      for (int i = 0; i < n; i++)
         if (i % int'(DECIM) == 0)
            sb.push_back({(with_last && (i == last_sym)) ? 1'b1 : 1'b0, samp[i]});
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = samp[i];
         in_last  = with_last && (i == n - 1);
         t = 0;
         @(negedge clk);
         while (!in_ready && t < 2000) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge clk);
      while ((busy || out_valid) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check("idle_timeout", 32'(busy | out_valid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   int f0, p0, fl0;

   initial begin
      // Reset state
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_fir_en", 32'(fir_en), 32'd0);
      check("rst_fir_din", 32'(fir_din), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
`ifdef RX_FILTER_SEQUENCER_STATS_EN
      check("rst_sym_count", 32'(sym_count), 32'd0);
`endif
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // 8-sample burst: symbols 1 and 5, 72 shifts
      for (int i = 0; i < 8; i++) samp[i] = 16'(i + 1);
      f0 = fen_cnt; p0 = pops;
      send_burst(8, 1'b1);
      wait_idle();
      check("b8_shifts", 32'(fen_cnt - f0), 32'd72);
      check("b8_symbols", 32'(pops - p0), 32'd2);
      check("b8_sb_empty", 32'(sb.size()), 32'd0);
      check("b8_busy", 32'(busy), 32'd0);

      // Single sample burst
      samp[0] = 16'h00AA;
      f0 = fen_cnt; p0 = pops; fl0 = flush_cnt;
      send_burst(1, 1'b1);
      wait_idle();
      check("b1_shifts", 32'(fen_cnt - f0), 32'd65);
      check("b1_flush", 32'(flush_cnt - fl0), 32'd64);
      check("b1_symbols", 32'(pops - p0), 32'd1);

      // Backpressure: captures at shifts 33,37,41 fill 3 entries then shifting stalls
      for (int i = 0; i < 40; i++) samp[i] = 16'(16'h0100 + i * 3);
      out_ready = 1'b0;
      f0 = fen_cnt; p0 = pops;
      send_burst(40, 1'b1);
      repeat (200) @(posedge clk);
      @(negedge clk);
      check("bp_stall_shifts", 32'(fen_cnt - f0), 32'd41);
      check("bp_fir_en", 32'(fir_en), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_idle();
      check("bp_symbols", 32'(pops - p0), 32'd10);
      check("bp_sb_empty", 32'(sb.size()), 32'd0);
      check("bp_shifts", 32'(fen_cnt - f0), 32'd104);

      // Reset mid-RUN with two symbols queued
      for (int i = 0; i < 38; i++) samp[i] = 16'(16'h2000 + i);
      out_ready = 1'b0;
      send_burst(38, 1'b0);
      @(negedge clk);
      check("mr_queued", 32'(out_valid), 32'd1);
      check("mr_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("mr_rst_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      sb.delete();
      @(negedge clk);
      check("mr_out_valid", 32'(out_valid), 32'd0);
      check("mr_busy_after", 32'(busy), 32'd0);
      check("mr_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 out_ready = 1'b1;

      // in_last offered during FLUSH is ignored
      for (int i = 0; i < 8; i++) samp[i] = 16'(i * 3 + 7);
      f0 = fen_cnt; p0 = pops;
      send_burst(8, 1'b1);
      in_valid = 1'b1; in_last = 1'b1; in_data = 16'hDEAD;
      repeat (5) begin
         @(negedge clk);
         check("flush_ignore", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1 in_valid = 1'b0; in_last = 1'b0;
      wait_idle();
      check("fl_symbols", 32'(pops - p0), 32'd2);
      check("fl_shifts", 32'(fen_cnt - f0), 32'd72);
      check("fl_sb_empty", 32'(sb.size()), 32'd0);

      // 12-sample burst, then a short burst to observe the statistic clearing
      for (int i = 0; i < 12; i++) samp[i] = 16'(16'h0400 + i);
      p0 = pops;
      send_burst(12, 1'b1);
      wait_idle();
      check("b12_symbols", 32'(pops - p0), 32'd3);
`ifdef RX_FILTER_SEQUENCER_STATS_EN
      check("stats_after_drain", 32'(sym_count), 32'd3);
`endif
      for (int i = 0; i < 4; i++) samp[i] = 16'(16'h0500 + i);
      send_burst(4, 1'b1);
`ifdef RX_FILTER_SEQUENCER_STATS_EN
      @(negedge clk);
      check("stats_cleared", 32'(sym_count), 32'd0);
`endif
      wait_idle();
`ifdef RX_FILTER_SEQUENCER_STATS_EN
      check("stats_b4", 32'(sym_count), 32'd1);
`endif
      check("b4_sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
